// File: rtl/index_mem_loader.sv
// Write-side front end for the dual index memory: fills the A and B RAMs pairwise
// from one interleaved byte stream, pads the shorter list, and appends a PAD sentinel row.
module index_mem_loader #(
   parameter int                DATA_W = 8,
   parameter int                ADDR_W = 4,
   parameter logic [DATA_W-1:0] PAD    = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   len_a,
   input  logic [ADDR_W:0]   len_b,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] i1,
   output logic [DATA_W-1:0] i2,
   output logic [ADDR_W-1:0] cnt1,
   output logic [ADDR_W-1:0] cnt2,
   output logic              wr_en,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_GET_A, S_GET_B, S_WRITE, S_TERM, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     len_a_q, len_a_d, len_b_q, len_b_d, n_q, n_d, k_q, k_d;
   logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
   logic [DATA_W-1:0]   i1_q, i1_d, i2_q, i2_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                wr_en_q, wr_en_d, in_ready_q, in_ready_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                accept;

   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
      return (l > DEPTH_L) ? DEPTH_L : l;
   endfunction

   assign accept = in_valid && in_ready_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         i1_q       <= '0;
         i2_q       <= '0;
         cnt_q      <= '0;
         wr_en_q    <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         i1_q       <= i1_d;
         i2_q       <= i2_d;
         cnt_q      <= cnt_d;
         wr_en_q    <= wr_en_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
      len_a_q <= len_a_d;
      len_b_q <= len_b_d;
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
   end

   always_comb begin
      state_d = state_q;
      len_a_d = len_a_q;
      len_b_d = len_b_q;
      n_d     = n_q;
      k_d     = k_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            len_a_d = clamp_len(len_a);
            len_b_d = clamp_len(len_b);
            n_d     = (len_a_d > len_b_d) ? len_a_d : len_b_d;
            k_d     = '0;
            state_d = (n_d == '0) ? S_TERM : S_GET_A;
         end
         // Padded slots cost one cycle but never stall on the stream.
         S_GET_A: if (k_q >= len_a_q) begin
            a_d     = PAD;
            state_d = S_GET_B;
         end else if (accept) begin
            a_d     = in_data;
            state_d = S_GET_B;
         end
         S_GET_B: if (k_q >= len_b_q) begin
            b_d     = PAD;
            state_d = S_WRITE;
         end else if (accept) begin
            b_d     = in_data;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            k_d = k_q + 1'b1;
            if (k_d == n_q) state_d = (n_q < DEPTH_L) ? S_TERM : S_DONE;
            else            state_d = S_GET_A;
         end
         S_TERM:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      i1_d       = i1_q;
      i2_d       = i2_q;
      cnt_d      = cnt_q;
      wr_en_d    = 1'b0;
      in_ready_d = 1'b0;
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      unique case (state_d)
         S_GET_A: in_ready_d = (k_d < len_a_d);
         S_GET_B: in_ready_d = (k_d < len_b_d);
         S_WRITE: begin
            wr_en_d = 1'b1;
            i1_d    = a_d;
            i2_d    = b_d;
            cnt_d   = k_d[ADDR_W-1:0];
         end
         S_TERM: begin
            wr_en_d = 1'b1;
            i1_d    = PAD;
            i2_d    = PAD;
            cnt_d   = n_d[ADDR_W-1:0];
         end
         default: ;
      endcase
   end

   assign in_ready = in_ready_q;
   assign i1       = i1_q;
   assign i2       = i2_q;
   assign cnt1     = cnt_q;
   assign cnt2     = cnt_q;
   assign wr_en    = wr_en_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_index_mem_loader.sv
// Directed bench for index_mem_loader: drives interleaved A/B streams and compares
// every captured RAM write against hand-computed rows.
module tb_index_mem_loader;

   logic       clk = 1'b0;
   logic       reset, start, in_valid, in_ready, wr_en, busy, done;
   logic [4:0] len_a, len_b;
   logic [7:0] in_data, i1, i2;
   logic [3:0] cnt1, cnt2;

   int total = 0;
   int bad   = 0;

   logic [7:0] stim [32];
   logic [7:0] wa [$];
   logic [7:0] wb [$];
   logic [3:0] wadr [$];
   int  nacc, done_cyc, last_wr_cyc;
   bit  got_done, saw_ready, aborted, cnt_mismatch;

   always #5 clk = ~clk;

   index_mem_loader dut (
      .clk(clk), .reset(reset), .start(start), .len_a(len_a), .len_b(len_b),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .i1(i1), .i2(i2), .cnt1(cnt1), .cnt2(cnt2), .wr_en(wr_en),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] row(input int idx);
      if (idx < wa.size()) return {12'h0, wa[idx], wb[idx], wadr[idx]};
      return 32'hDEAD_BEEF;
   endfunction

   task automatic exp_row(input string tag, input int idx, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] adr);
      chk(tag, row(idx), {12'h0, a, b, adr});
   endtask

   task automatic run_load(input logic [4:0] la, input logic [4:0] lb, input int nbytes,
                           input bit toggle, input bit noise, input bit abort,
                           input int maxcyc);
      int idx;
      idx = 0;
      wa.delete(); wb.delete(); wadr.delete();
      nacc = 0; done_cyc = -1; last_wr_cyc = -1;
      got_done = 0; saw_ready = 0; aborted = 0; cnt_mismatch = 0;
      @(negedge clk);
      start = 1'b1; len_a = la; len_b = lb;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < maxcyc && !got_done && !aborted; cyc++) begin
         in_valid = (idx < nbytes) && (!toggle || (cyc % 2 == 0));
         in_data  = (idx < nbytes) ? stim[idx] : 8'h00;
         if (noise) begin
            start = cyc[0]; len_a = 5'd0; len_b = 5'd0;
         end
         @(negedge clk);
         if (in_ready) saw_ready = 1;
         if (cnt1 !== cnt2) cnt_mismatch = 1;
         if (in_valid && in_ready) begin
            nacc++;
            idx++;
         end
         if (wr_en) begin
            wa.push_back(i1); wb.push_back(i2); wadr.push_back(cnt1);
            last_wr_cyc = cyc;
         end
         if (done) begin
            got_done = 1;
            done_cyc = cyc;
         end
         if (abort && wa.size() > 0) begin
            reset = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0; start = 1'b0;
            @(negedge clk);
            chk("reset_abort_outputs",
                {4'h0, i1, i2, cnt1, cnt2, wr_en, in_ready, busy, done}, 32'h0);
            reset = 1'b0;
            aborted = 1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0; in_valid = 1'b0;
      if (!abort) begin
         chk("done_seen", {31'h0, got_done}, 32'h1);
         @(negedge clk);
         chk("idle_after_done", {30'h0, busy, done}, 32'h0);
      end
      chk("cnt2_tracks_cnt1", {31'h0, cnt_mismatch}, 32'h0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      len_a = 5'd0; len_b = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {4'h0, i1, i2, cnt1, cnt2, wr_en, in_ready, busy, done}, 32'h0);
      reset = 1'b0;

      // 1: equal lengths, steady stream, start pulses while busy
      stim[0] = 8'h10; stim[1] = 8'h20; stim[2] = 8'h11;
      stim[3] = 8'h21; stim[4] = 8'h12; stim[5] = 8'h22;
      run_load(5'd3, 5'd3, 6, 1'b0, 1'b1, 1'b0, 100);
      chk("t1_nwrites", wa.size(), 4);
      exp_row("t1_row0", 0, 8'h10, 8'h20, 4'd0);
      exp_row("t1_row1", 1, 8'h11, 8'h21, 4'd1);
      exp_row("t1_row2", 2, 8'h12, 8'h22, 4'd2);
      exp_row("t1_term", 3, 8'hFF, 8'hFF, 4'd3);
      chk("t1_done_after_term", done_cyc, last_wr_cyc + 1);
      chk("t1_bytes", nacc, 6);

      // 2: B shorter than A
      stim[0] = 8'd5; stim[1] = 8'd7; stim[2] = 8'd6; stim[3] = 8'd8; stim[4] = 8'd9;
      run_load(5'd4, 5'd1, 5, 1'b0, 1'b0, 1'b0, 100);
      chk("t2_nwrites", wa.size(), 5);
      exp_row("t2_row0", 0, 8'd5, 8'd7,  4'd0);
      exp_row("t2_row1", 1, 8'd6, 8'hFF, 4'd1);
      exp_row("t2_row2", 2, 8'd8, 8'hFF, 4'd2);
      exp_row("t2_row3", 3, 8'd9, 8'hFF, 4'd3);
      exp_row("t2_term", 4, 8'hFF, 8'hFF, 4'd4);
      chk("t2_bytes", nacc, 5);

      // 3: full depth, no terminator row
      for (int k = 0; k < 16; k++) begin
         stim[2*k]   = 8'(k);
         stim[2*k+1] = 8'(8'h80 + k);
      end
      run_load(5'd16, 5'd16, 32, 1'b0, 1'b0, 1'b0, 200);
      chk("t3_nwrites", wa.size(), 16);
      for (int k = 0; k < 16; k++)
         exp_row($sformatf("t3_row%0d", k), k, 8'(k), 8'(8'h80 + k), 4'(k));
      chk("t3_bytes", nacc, 32);

      // 4: empty lists
      run_load(5'd0, 5'd0, 0, 1'b0, 1'b0, 1'b0, 20);
      chk("t4_nwrites", wa.size(), 1);
      exp_row("t4_term", 0, 8'hFF, 8'hFF, 4'd0);
      chk("t4_ready_never", {31'h0, saw_ready}, 32'h0);

      // 5: valid toggling every cycle
      stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03; stim[3] = 8'h04;
      run_load(5'd2, 5'd2, 4, 1'b1, 1'b0, 1'b0, 100);
      chk("t5_nwrites", wa.size(), 3);
      exp_row("t5_row0", 0, 8'h01, 8'h02, 4'd0);
      exp_row("t5_row1", 1, 8'h03, 8'h04, 4'd1);
      exp_row("t5_term", 2, 8'hFF, 8'hFF, 4'd2);

      // 6: reset after the first write, then a fresh load from address 0
      stim[0] = 8'h31; stim[1] = 8'h41; stim[2] = 8'h32;
      stim[3] = 8'h42; stim[4] = 8'h33; stim[5] = 8'h43;
      run_load(5'd3, 5'd3, 6, 1'b0, 1'b0, 1'b1, 100);
      chk("t6_aborted", {31'h0, aborted}, 32'h1);
      stim[0] = 8'hAA; stim[1] = 8'hBB;
      run_load(5'd1, 5'd1, 2, 1'b0, 1'b0, 1'b0, 100);
      chk("t6_nwrites", wa.size(), 2);
      exp_row("t6_row0", 0, 8'hAA, 8'hBB, 4'd0);
      exp_row("t6_term", 1, 8'hFF, 8'hFF, 4'd1);

      // 7: oversize length clamps to 16
      for (int k = 0; k < 16; k++) stim[k] = 8'(8'h40 + k);
      run_load(5'd31, 5'd0, 16, 1'b0, 1'b0, 1'b0, 200);
      chk("t7_nwrites", wa.size(), 16);
      exp_row("t7_row0", 0, 8'h40, 8'hFF, 4'd0);
      exp_row("t7_row15", 15, 8'h4F, 8'hFF, 4'd15);
      chk("t7_bytes", nacc, 16);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
